// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: the operating-mode encoding.
package shift_pkg;

    // Two-bit mode field; all four codes are meaningful, so the decode is total.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SHR  = 2'd1,
        MODE_SHL  = 2'd2,
        MODE_LOAD = 2'd3
    } shift_mode_e;

endpackage : shift_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter from 0 to MAX with a registered full flag and a
// one-cycle done pulse on the edge where the count first reaches MAX.
// clr has priority over inc. No new done is raised while already saturated.
module sat_counter #(
    parameter  int MAX   = 8,
    localparam int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             full_r;
    logic             done_r;
    logic             done_next_s;

    // Next count and done pulse: clear wins, increment stops at MAX.
    always_comb begin
        cnt_next_s  = cnt_r;
        done_next_s = 1'b0;
        if (clr) begin
            cnt_next_s  = ZERO_C;
            done_next_s = 1'b0;
        end else if (inc) begin
            if (cnt_r != MAX_C) begin
                cnt_next_s  = cnt_r + ONE_C;
                done_next_s = (cnt_r == LAST_C);
            end else begin
                cnt_next_s  = cnt_r;
                done_next_s = 1'b0;
            end
        end else begin
            cnt_next_s  = cnt_r;
            done_next_s = 1'b0;
        end
    end

    // Count, full and done registers; full tracks the count it is stored with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= ZERO_C;
            full_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            full_r <= (cnt_next_s == MAX_C);
            done_r <= done_next_s;
        end
    end

    assign cnt  = cnt_r;
    assign full = full_r;
    assign done = done_r;

endmodule : sat_counter

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift-right, shift-left and parallel load,
// with a saturating shift counter that flags a completely shifted word.
// Optional feature macro: SHREG_ROTATE_EN -- when defined, rot=1 turns the
// shifts into rotates; when undefined, rot is ignored and no rotate logic exists.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  shift_mode_e       mode,
    input  logic              si_r,
    input  logic              si_l,
    input  logic [WIDTH-1:0]  pi,
    input  logic              rot,
    output logic [WIDTH-1:0]  po,
    output logic              so_r,
    output logic              so_l,
    output logic [CNT_W-1:0]  cnt,
    output logic              full,
    output logic              done
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] shr_val_s;
    logic [WIDTH-1:0] shl_val_s;
    logic             fill_r_s;   // bit entering q[WIDTH-1] on a right shift
    logic             fill_l_s;   // bit entering q[0] on a left shift
    logic             inc_s;
    logic             clr_s;

`ifdef SHREG_ROTATE_EN
    // Rotation recirculates the outgoing bit instead of taking serial input.
    assign fill_r_s = rot ? q_r[0]       : si_r;
    assign fill_l_s = rot ? q_r[WIDTH-1] : si_l;
`else
    // rot has no function in this build; tie it off so it is visibly unused.
    logic unused_rot_s;
    assign unused_rot_s = rot;
    assign fill_r_s     = si_r;
    assign fill_l_s     = si_l;
`endif

    // A one-bit register has nothing to shift along; the fill bit replaces it.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_val_s = fill_r_s;
            assign shl_val_s = fill_l_s;
        end else begin : g_wn
            assign shr_val_s = {fill_r_s, q_r[WIDTH-1:1]};
            assign shl_val_s = {q_r[WIDTH-2:0], fill_l_s};
        end
    endgenerate

    // Datapath mux and counter controls; en=0 freezes everything.
    always_comb begin
        q_next_s = q_r;
        inc_s    = 1'b0;
        clr_s    = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_next_s = q_r;
                end
                MODE_SHR: begin
                    q_next_s = shr_val_s;
                    inc_s    = 1'b1;
                end
                MODE_SHL: begin
                    q_next_s = shl_val_s;
                    inc_s    = 1'b1;
                end
                MODE_LOAD: begin
                    q_next_s = pi;
                    clr_s    = 1'b1;
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Shift register state; reset discards any partially shifted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= q_next_s;
        end
    end

    sat_counter #(
        .MAX (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_s),
        .clr   (clr_s),
        .cnt   (cnt),
        .full  (full),
        .done  (done)
    );

    assign po   = q_r;
    assign so_r = q_r[0];
    assign so_l = q_r[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a WIDTH=4 instance for the main scenarios,
// plus WIDTH=1 and WIDTH=16 instances checked against a small shift model.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    shift_mode_e mode;
    logic        si_r, si_l, rot;

    logic [3:0]  pi4;
    logic [3:0]  po4;
    logic        so_r4, so_l4, full4, done4;
    logic [2:0]  cnt4;

    logic [0:0]  pi1;
    logic [0:0]  po1;
    logic        so_r1, so_l1, full1, done1;
    logic [0:0]  cnt1;

    logic [15:0] pi16;
    logic [15:0] po16;
    logic        so_r16, so_l16, full16, done16;
    logic [4:0]  cnt16;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] m16;
    logic        m1;
    logic [3:0]  rot_exp;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
        .pi(pi4), .rot(rot), .po(po4), .so_r(so_r4), .so_l(so_l4), .cnt(cnt4),
        .full(full4), .done(done4)
    );

    univ_shift_reg #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
        .pi(pi1), .rot(rot), .po(po1), .so_r(so_r1), .so_l(so_l1), .cnt(cnt1),
        .full(full1), .done(done1)
    );

    univ_shift_reg #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
        .pi(pi16), .rot(rot), .po(po16), .so_r(so_r16), .so_l(so_l16), .cnt(cnt16),
        .full(full16), .done(done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before any sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD;
        si_r = 1'b0; si_l = 1'b0; rot = 1'b0;
        pi4 = 4'h0; pi1 = 1'b0; pi16 = 16'h0;
        #2;
        check("rst_po",   32'(po4),   32'h0);
        check("rst_cnt",  32'(cnt4),  32'h0);
        check("rst_full", 32'(full4), 32'h0);
        check("rst_done", 32'(done4), 32'h0);
        step();
        rst_n = 1'b1;

        // 1. load then asynchronous reset between edges
        en = 1'b1; mode = MODE_LOAD; pi4 = 4'hA;
        step();
        check("load_a", 32'(po4), 32'hA);
        mode = MODE_SHR; si_r = 1'b1;
        step();
        check("shr_pre_rst_cnt", 32'(cnt4), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_po",   32'(po4),   32'h0);
        check("async_rst_cnt",  32'(cnt4),  32'h0);
        check("async_rst_full", 32'(full4), 32'h0);
        en = 1'b0;
        step();
        check("rst_held_po", 32'(po4), 32'h0);
        rst_n = 1'b1;

        // 2. SIPO: 1,0,1,1 on si_r
        en = 1'b1; mode = MODE_SHR;
        si_r = 1'b1; step();
        check("sipo1_po", 32'(po4), 32'h8); check("sipo1_done", 32'(done4), 32'h0);
        check("sipo1_cnt", 32'(cnt4), 32'h1);
        si_r = 1'b0; step();
        check("sipo2_po", 32'(po4), 32'h4); check("sipo2_done", 32'(done4), 32'h0);
        si_r = 1'b1; step();
        check("sipo3_po", 32'(po4), 32'hA); check("sipo3_done", 32'(done4), 32'h0);
        check("sipo3_full", 32'(full4), 32'h0);
        si_r = 1'b1; step();
        check("sipo4_po", 32'(po4), 32'hD); check("sipo4_done", 32'(done4), 32'h1);
        check("sipo4_cnt", 32'(cnt4), 32'h4); check("sipo4_full", 32'(full4), 32'h1);
        check("sipo4_so_r", 32'(so_r4), 32'h1);

        // 4. en=0 blocks a load; a shift while saturated keeps cnt and no done
        en = 1'b0; mode = MODE_LOAD; pi4 = 4'hF;
        step();
        check("en0_po", 32'(po4), 32'hD); check("en0_cnt", 32'(cnt4), 32'h4);
        check("en0_done", 32'(done4), 32'h0);
        en = 1'b1; mode = MODE_SHR; si_r = 1'b0;
        step();
        check("sat_po", 32'(po4), 32'h6); check("sat_cnt", 32'(cnt4), 32'h4);
        check("sat_done", 32'(done4), 32'h0); check("sat_full", 32'(full4), 32'h1);
        mode = MODE_HOLD; si_r = 1'b1;
        step();
        check("hold_po", 32'(po4), 32'h6); check("hold_cnt", 32'(cnt4), 32'h4);

        // 3. PISO: load 9, shift left with si_l=0, watch so_l
        mode = MODE_LOAD; pi4 = 4'h9;
        step();
        check("piso_load_cnt",  32'(cnt4),  32'h0);
        check("piso_load_full", 32'(full4), 32'h0);
        mode = MODE_SHL; si_l = 1'b0;
        check("piso_so_l0", 32'(so_l4), 32'h1); step();
        check("piso_so_l1", 32'(so_l4), 32'h0); step();
        check("piso_so_l2", 32'(so_l4), 32'h0); step();
        check("piso_so_l3", 32'(so_l4), 32'h1); check("piso_done3", 32'(done4), 32'h0);
        step();
        check("piso_po", 32'(po4), 32'h0); check("piso_done4", 32'(done4), 32'h1);
        check("piso_full", 32'(full4), 32'h1);
        step();
        check("piso_done_once", 32'(done4), 32'h0);

        // 5. rotate: load 1, rot=1, four left shifts with si_l=0
        mode = MODE_LOAD; pi4 = 4'h1; rot = 1'b1; si_l = 1'b0; si_r = 1'b0;
        step();
        mode = MODE_SHL;
        step(); check("rot1", 32'(po4), 32'h2);
        step(); check("rot2", 32'(po4), 32'h4);
        step(); check("rot3", 32'(po4), 32'h8);
        step();
`ifdef SHREG_ROTATE_EN
        rot_exp = 4'h1;
`else
        rot_exp = 4'h0;
`endif
        check("rot4", 32'(po4), 32'(rot_exp));
        check("rot_done", 32'(done4), 32'h1);
        mode = MODE_LOAD; pi4 = 4'h1;
        step();
        mode = MODE_SHR;
        step();
`ifdef SHREG_ROTATE_EN
        rot_exp = 4'h8;
`else
        rot_exp = 4'h0;
`endif
        check("rot_shr", 32'(po4), 32'(rot_exp));
        rot = 1'b0;

        // 6. WIDTH=1 and WIDTH=16 against a shift model, alternating SHR/SHL
        mode = MODE_LOAD; pi1 = 1'b1; pi16 = 16'hC35A;
        step();
        m1 = 1'b1; m16 = 16'hC35A;
        check("w1_load", 32'(po1), 32'(m1)); check("w16_load", 32'(po16), 32'(m16));
        check("w1_load_cnt", 32'(cnt1), 32'h0);
        mode = MODE_SHR; si_r = 1'b0;
        step();
        check("w1_done", 32'(done1), 32'h1); check("w1_full", 32'(full1), 32'h1);
        m1 = 1'b0; m16 = {1'b0, m16[15:1]};
        for (int i = 0; i < 40; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = (i % 2 == 0) ? MODE_SHL : MODE_SHR;
            si_r = 1'($urandom_range(0, 1));
            si_l = 1'($urandom_range(0, 1));
            if (en) begin
                if (mode == MODE_SHR) begin
                    m1 = si_r; m16 = {si_r, m16[15:1]};
                end else begin
                    m1 = si_l; m16 = {m16[14:0], si_l};
                end
            end
            step();
            check("w1_stream",  32'(po1),  32'(m1));
            check("w16_stream", 32'(po16), 32'(m16));
        end
        check("w16_cnt_sat", 32'(cnt16), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_univ_shift_reg
